// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron core and its downstream consumers.
// Holds the Q2.16 membrane-potential format, the nominal spike threshold,
// and the layout of the spike event word {wrap, spike, ts} at the
// default 16-bit timestamp width.
package neuron_pkg;

    localparam int V_W  = 18;
    localparam int FRAC = 16;

    localparam logic signed [V_W-1:0] THRESH_DEFAULT = 18'sh0_4CCC;

    localparam int TS_W_DEFAULT  = 16;
    localparam int EVT_TS_LSB    = 0;
    localparam int EVT_SPIKE_BIT = TS_W_DEFAULT;
    localparam int EVT_WRAP_BIT  = TS_W_DEFAULT + 1;

    typedef struct packed {
        logic                    wrap;
        logic                    spike;
        logic [TS_W_DEFAULT-1:0] ts;
    } evt_word_t;

endpackage

// File: rtl/spike_evt_fifo.sv
// Synchronous FIFO for spike event words.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset (empties the FIFO)
//   push, din    - write request and data
//   pop, dout    - read request and head-of-queue data (zero when empty)
//   empty, full  - occupancy flags
// A push while full is accepted only if a pop happens in the same cycle;
// otherwise it is discarded and the caller is expected to flag overflow.
module spike_evt_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // When full, the slot being written is the one being read out this cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/spike_event_encoder.sv
// Spike detector and event encoder for the Izhikevich neuron core output.
// Each valid sample of the membrane potential is compared against the
// threshold; accepted spikes (outside the refractory interval) are tagged
// with the sample timestamp and queued. Timestamp wrap is marked in the
// event stream so the consumer can extend time. A windowed spike-rate
// count is published for debug.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   v_in, v_valid       - signed Q2.16 membrane potential and sample strobe
//   thresh              - signed Q2.16 spike threshold
//   evt_data/valid/ready- event readout, {wrap, spike, ts}
//   rate_out, rate_stb  - spikes in last completed window, update pulse
//   ovf, ovf_clr        - sticky event-drop flag and its clear
module spike_event_encoder
    import neuron_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int TS_W       = 16,
    parameter int REFRACT    = 4,
    parameter int WINDOW     = 256,
    parameter int RATE_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic signed [V_W-1:0] v_in,
    input  logic                  v_valid,
    input  logic signed [V_W-1:0] thresh,
    output logic [TS_W+1:0]       evt_data,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [RATE_W-1:0]     rate_out,
    output logic                  rate_stb,
    output logic                  ovf,
    input  logic                  ovf_clr
);

    localparam int EVT_W = TS_W + 2;
    localparam int RF_W  = (REFRACT < 1) ? 1 : $clog2(REFRACT + 1);
    localparam int WIN_W = (WINDOW < 2) ? 1 : $clog2(WINDOW);

    localparam logic [RF_W-1:0]   REFRACT_LD = RF_W'(REFRACT);
    localparam logic [RF_W-1:0]   RF_ONE     = 1;
    localparam logic [WIN_W-1:0]  WIN_LAST   = WIN_W'(WINDOW - 1);
    localparam logic [WIN_W-1:0]  WIN_ONE    = 1;
    localparam logic [TS_W-1:0]   TS_ONE     = 1;
    localparam logic [RATE_W-1:0] RATE_ONE   = 1;
    localparam logic [RATE_W-1:0] RATE_MAX   = '1;

    logic [TS_W-1:0]   ts;
    logic [RF_W-1:0]   refr_cnt;
    logic [WIN_W-1:0]  win_cnt;
    logic [RATE_W-1:0] spike_acc;
    logic [RATE_W-1:0] acc_next;
    logic              candidate;
    logic              accept;
    logic              ts_wrap;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [EVT_W-1:0]  push_word;

    assign candidate = v_valid && (v_in > thresh);
    assign accept    = candidate && (refr_cnt == '0);
    assign ts_wrap   = &ts;
    // Spike and wrap on the same sample share one word.
    assign push      = accept || (v_valid && ts_wrap);
    assign push_word = {ts_wrap, accept, ts};
    assign pop       = evt_valid && evt_ready;
    assign evt_valid = !fifo_empty;
    assign acc_next  = (accept && (spike_acc != RATE_MAX)) ? spike_acc + RATE_ONE : spike_acc;

    spike_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_word),
        .pop   (pop),
        .dout  (evt_data),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts        <= '0;
            refr_cnt  <= '0;
            win_cnt   <= '0;
            spike_acc <= '0;
            rate_out  <= '0;
            rate_stb  <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            rate_stb <= 1'b0;

            // A drop in the same cycle as a clear keeps the flag set.
            if (push && fifo_full && !pop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end

            if (v_valid) begin
                ts <= ts + TS_ONE;

                if (accept) begin
                    refr_cnt <= REFRACT_LD;
                end else if (refr_cnt != '0) begin
                    refr_cnt <= refr_cnt - RF_ONE;
                end

                if (win_cnt == WIN_LAST) begin
                    rate_out  <= acc_next;
                    rate_stb  <= 1'b1;
                    spike_acc <= '0;
                    win_cnt   <= '0;
                end else begin
                    spike_acc <= acc_next;
                    win_cnt   <= win_cnt + WIN_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_spike_event_encoder.sv
// Directed bench for spike_event_encoder. Three instances share one
// stimulus stream: u_a with default parameters, u_w with a 4-bit
// timestamp for wrap behaviour, u_r with a 16-sample window, no
// refractory interval and a 2-bit rate counter.
module tb_spike_event_encoder;
    import neuron_pkg::*;

    localparam logic signed [17:0] HI = 18'sh0_4CCD;
    localparam logic signed [17:0] EQ = 18'sh0_4CCC;
    localparam logic signed [17:0] LO = 18'sh3_4CCD;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic signed [17:0] v_in = LO;
    logic              v_valid = 1'b0;
    logic signed [17:0] thresh = EQ;
    logic              evt_ready = 1'b0;
    logic              ovf_clr = 1'b0;

    logic [17:0] evt_data_a;
    logic        evt_valid_a, rate_stb_a, ovf_a;
    logic [7:0]  rate_out_a;
    logic [5:0]  evt_data_w;
    logic        evt_valid_w, rate_stb_w, ovf_w;
    logic [7:0]  rate_out_w;
    logic [17:0] evt_data_r;
    logic        evt_valid_r, rate_stb_r, ovf_r;
    logic [1:0]  rate_out_r;

    spike_event_encoder u_a (
        .clk(clk), .rst(rst), .v_in(v_in), .v_valid(v_valid), .thresh(thresh),
        .evt_data(evt_data_a), .evt_valid(evt_valid_a), .evt_ready(evt_ready),
        .rate_out(rate_out_a), .rate_stb(rate_stb_a), .ovf(ovf_a), .ovf_clr(ovf_clr)
    );

    spike_event_encoder #(.TS_W(4)) u_w (
        .clk(clk), .rst(rst), .v_in(v_in), .v_valid(v_valid), .thresh(thresh),
        .evt_data(evt_data_w), .evt_valid(evt_valid_w), .evt_ready(evt_ready),
        .rate_out(rate_out_w), .rate_stb(rate_stb_w), .ovf(ovf_w), .ovf_clr(ovf_clr)
    );

    spike_event_encoder #(.WINDOW(16), .REFRACT(0), .RATE_W(2)) u_r (
        .clk(clk), .rst(rst), .v_in(v_in), .v_valid(v_valid), .thresh(thresh),
        .evt_data(evt_data_r), .evt_valid(evt_valid_r), .evt_ready(evt_ready),
        .rate_out(rate_out_r), .rate_stb(rate_stb_r), .ovf(ovf_r), .ovf_clr(ovf_clr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic signed [17:0] v;
        logic               vv;
        logic               rdy;
        logic               exp_valid;
        logic [17:0]        exp_data;
    } vec_t;

    vec_t tbl[13];
    logic [17:0] got_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic signed [17:0] v, input logic vv, input logic rdy, input logic clr);
        v_in      = v;
        v_valid   = vv;
        evt_ready = rdy;
        ovf_clr   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        v_valid   = 1'b0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        v_in      = LO;
        #1;
        check("rst evt_valid", 32'(evt_valid_a), 32'd0);
        check("rst evt_data", 32'(evt_data_a), 32'd0);
        check("rst ovf", 32'(ovf_a), 32'd0);
        check("rst rate_out", 32'(rate_out_a), 32'd0);
        check("rst rate_stb", 32'(rate_stb_a), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Threshold crossing, equality, refractory and gaps in v_valid.
        tbl[0]  = '{LO, 1'b1, 1'b0, 1'b0, 18'h0};
        tbl[1]  = '{LO, 1'b1, 1'b0, 1'b0, 18'h0};
        tbl[2]  = '{LO, 1'b1, 1'b0, 1'b0, 18'h0};
        tbl[3]  = '{LO, 1'b1, 1'b0, 1'b0, 18'h0};
        tbl[4]  = '{LO, 1'b1, 1'b0, 1'b0, 18'h0};
        tbl[5]  = '{HI, 1'b1, 1'b0, 1'b1, 18'h10005};
        tbl[6]  = '{EQ, 1'b1, 1'b0, 1'b1, 18'h10005};
        tbl[7]  = '{HI, 1'b0, 1'b0, 1'b1, 18'h10005};
        tbl[8]  = '{LO, 1'b1, 1'b1, 1'b0, 18'h0};
        tbl[9]  = '{HI, 1'b1, 1'b1, 1'b0, 18'h0};
        tbl[10] = '{HI, 1'b1, 1'b1, 1'b0, 18'h0};
        tbl[11] = '{HI, 1'b1, 1'b0, 1'b1, 18'h1000A};
        tbl[12] = '{LO, 1'b1, 1'b1, 1'b0, 18'h0};

        // Ten sub-threshold samples, then a spike carries ts=10.
        do_reset();
        for (int i = 0; i < 10; i++) step(LO, 1'b1, 1'b0, 1'b0);
        check("quiet evt_valid", 32'(evt_valid_a), 32'd0);
        check("quiet ovf", 32'(ovf_a), 32'd0);
        step(HI, 1'b1, 1'b0, 1'b0);
        check("ts10 evt_valid", 32'(evt_valid_a), 32'd1);
        check("ts10 evt_data", 32'(evt_data_a), 32'h1000A);

        do_reset();
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].v, tbl[i].vv, tbl[i].rdy, 1'b0);
            check($sformatf("vec%0d evt_valid", i), 32'(evt_valid_a), 32'(tbl[i].exp_valid));
            check($sformatf("vec%0d evt_data", i), 32'(evt_data_a), 32'(tbl[i].exp_data));
        end

        // Continuous spiking with refractory interval 4.
        do_reset();
        got_q.delete();
        for (int i = 0; i < 18; i++) begin
            step(HI, 1'b1, 1'b1, 1'b0);
            if (evt_valid_a) got_q.push_back(evt_data_a);
        end
        check("refract count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_q.size())
                check($sformatf("refract evt%0d", i), 32'(got_q[i]), 32'h10000 + 32'(i * 5));
        end

        // Timestamp wrap with 4-bit ts: spike on the wrap sample.
        do_reset();
        for (int i = 0; i < 15; i++) step(LO, 1'b1, 1'b1, 1'b0);
        check("wrap pre evt_valid", 32'(evt_valid_w), 32'd0);
        step(HI, 1'b1, 1'b1, 1'b0);
        check("wrap spike evt_valid", 32'(evt_valid_w), 32'd1);
        check("wrap spike evt_data", 32'(evt_data_w), 32'h3F);
        step(LO, 1'b1, 1'b1, 1'b0);
        check("wrap spike single", 32'(evt_valid_w), 32'd0);

        // Wrap marker only, then a spike at ts 0 after the wrap.
        do_reset();
        for (int i = 0; i < 16; i++) step(LO, 1'b1, 1'b1, 1'b0);
        check("wrap marker evt_data", 32'(evt_data_w), 32'h2F);
        step(HI, 1'b1, 1'b1, 1'b0);
        check("post wrap evt_valid", 32'(evt_valid_w), 32'd1);
        check("post wrap evt_data", 32'(evt_data_w), 32'h10);

        // Overflow: 9 accepted spikes into an 8-deep FIFO with no reads.
        do_reset();
        for (int i = 0; i < 36; i++) step(HI, 1'b1, 1'b0, 1'b0);
        check("ovf before 9th", 32'(ovf_a), 32'd0);
        for (int i = 36; i < 41; i++) step(HI, 1'b1, 1'b0, 1'b0);
        check("ovf after 9th", 32'(ovf_a), 32'd1);
        check("ovf evt_valid", 32'(evt_valid_a), 32'd1);
        for (int i = 41; i < 45; i++) step(HI, 1'b1, 1'b0, 1'b0);
        step(HI, 1'b1, 1'b0, 1'b1);
        check("ovf set beats clr", 32'(ovf_a), 32'd1);
        step(LO, 1'b0, 1'b0, 1'b1);
        check("ovf cleared", 32'(ovf_a), 32'd0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d evt_data", i), 32'(evt_data_a), 32'h10000 + 32'(i * 5));
            step(LO, 1'b0, 1'b1, 1'b0);
        end
        check("drain empty", 32'(evt_valid_a), 32'd0);

        // Rate window of 16 samples: 3 spikes, then none.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step((i == 1 || i == 4 || i == 8) ? HI : LO, 1'b1, 1'b1, 1'b0);
            if (i == 14) check("rate stb early", 32'(rate_stb_r), 32'd0);
        end
        check("rate1 stb", 32'(rate_stb_r), 32'd1);
        check("rate1 out", 32'(rate_out_r), 32'd3);
        for (int i = 0; i < 16; i++) begin
            step(LO, 1'b1, 1'b1, 1'b0);
            if (i == 0) check("rate stb one cycle", 32'(rate_stb_r), 32'd0);
        end
        check("rate2 stb", 32'(rate_stb_r), 32'd1);
        check("rate2 out", 32'(rate_out_r), 32'd0);

        // Saturation at 3 with 2-bit counter, then reset mid-window.
        do_reset();
        for (int i = 0; i < 16; i++) step((i < 6) ? HI : LO, 1'b1, 1'b1, 1'b0);
        check("rate sat out", 32'(rate_out_r), 32'd3);
        for (int i = 0; i < 7; i++) step((i == 2) ? HI : LO, 1'b1, 1'b0, 1'b0);
        check("midwin evt_valid", 32'(evt_valid_r), 32'd1);
        check("midwin rate_out", 32'(rate_out_r), 32'd3);
        rst = 1'b1;
        #1;
        check("async rst rate_out", 32'(rate_out_r), 32'd0);
        check("async rst evt_valid", 32'(evt_valid_r), 32'd0);
        check("async rst evt_data", 32'(evt_data_r), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spike_event_encoder.md
Name: spike_event_encoder

Overview:
- Downstream consumer of the Izhikevich neuron core. Samples the 18-bit signed 2.16 membrane potential v each enabled cycle and detects spikes (v strictly above threshold, the same condition that triggers the neuron's reset).
- Timestamps each spike and queues it in a small FIFO for readout over a valid/ready port.
- Also publishes a windowed spike-rate count for the debug/output mux.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of two, ≥2.
- TS_W, 16, timestamp counter width.
- REFRACT, 4, samples after an accepted spike during which further spikes are ignored; 0 = none.
- WINDOW, 256, valid samples per rate window; ≥1.
- RATE_W, 8, rate counter width; saturating.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- v_in  in  18  signed 2.16 membrane potential from the neuron core
- v_valid  in  1  v_in is a new sample this cycle (tied to the neuron's ena)
- thresh  in  18  signed 2.16 spike threshold; nominal 18'sh0_4CCC (0.30)
- evt_data  out  TS_W+2  {wrap, spike, ts[TS_W-1:0]}
- evt_valid  out  1  FIFO non-empty
- evt_ready  in  1  consumer accepts evt_data this cycle
- rate_out  out  RATE_W  spikes counted in the last completed window
- rate_stb  out  1  one-cycle pulse when rate_out updates
- ovf  out  1  sticky: an event was dropped
- ovf_clr  in  1  clears ovf

Behaviour:
- Reset (async, rst=1): ts=0, refractory counter=0, window counter=0, spike accumulator=0, FIFO empty, evt_valid=0, evt_data=0, rate_out=0, rate_stb=0, ovf=0.
- Only cycles with v_valid=1 are samples. Cycles with v_valid=0 change no state except FIFO pops and ovf_clr.
- Spike candidate: v_valid and signed(v_in) > signed(thresh). Strict comparison, so equality is not a spike.
- Accepted spike: candidate and refractory counter == 0. On acceptance the refractory counter loads REFRACT; each other sample decrements it if nonzero. A candidate during refractory is silently ignored and does not set ovf.
- ts equals the number of samples since reset, modulo 2^TS_W. The event carries the ts of the current sample; ts increments after that sample.
- Push condition: accepted spike OR (v_valid and ts == all-ones).
  - Word pushed = {ts==max, accepted_spike, ts}.
  - A spike on the wrap sample produces one word with both flags set. A wrap with no spike produces a marker word {1,0,max}.
  - Exactly one push per sample, at most.
- FIFO:
  - Registered, so a push at cycle N is visible at N+1; no combinational bypass.
  - Pop when evt_valid & evt_ready. evt_data is stable while evt_valid=1 and evt_ready=0.
  - Push and pop in the same cycle are both performed, including when full; count is unchanged.
  - Push while full without a pop drops the new word and sets ovf.
  - ovf_clr clears ovf. If a set and ovf_clr occur in the same cycle, set wins.
- Rate:
  - Accepted spikes increment the accumulator, saturating at 2^RATE_W-1.
  - On the WINDOW-th sample, rate_out ← accumulator including that sample's spike, and rate_stb=1 for exactly the next cycle.
  - The accumulator and window counter then restart at 0.
- Arithmetic: all comparisons are signed 18-bit. Counters wrap, except the rate accumulator, which saturates.
- Reset mid-operation discards FIFO contents and the partial window immediately.

Decomposition:
- Shared package neuron_pkg:
  - Q-format constants: V_W=18, FRAC=16, THRESH_DEFAULT=18'sh0_4CCC.
  - Event word field indices: EVT_WRAP_BIT, EVT_SPIKE_BIT, EVT_TS_LSB.
  - Typedef for the event word.
- One sub-module, spike_evt_fifo:
  - Parameterised width/depth synchronous FIFO, async active-high reset.
  - Ports: push, din, pop, dout, empty, full.
  - Push+pop-when-full semantics as above.
- Detection, refractory, timestamp and rate logic stay in the top.

Test Plan:
- Reset then samples v_in=18'sh3_4CCD (-0.7), thresh=18'sh0_4CCC for 10 cycles → evt_valid=0, ovf=0, ts internal=10.
- At sample 5, v_in=18'sh0_4CCD (just above); at sample 6, v_in=18'sh0_4CCC (equal); REFRACT=4 → one event {0,1,16'd5} visible the cycle after sample 5; no event for sample 6.
- v_in above threshold every sample, REFRACT=4 → events at ts 0,5,10,15; ready=1 throughout.
- TS_W=4, spike at sample 15 → single word {1,1,4'hF}. Same run without a spike at 15 → {1,0,4'hF}.
- FIFO_DEPTH=8, evt_ready=0, 9 accepted spikes → evt_valid=1, ovf=1, and the 9th is lost. Then pulse ovf_clr while pushing a 10th into the full FIFO with no pop → ovf stays 1. Drain → the 8 original ts values in order.
- WINDOW=16, REFRACT=0, 3 spikes in the first 16 samples, then 0 → rate_stb pulses after samples 16 and 32, with rate_out=3 then 0. Assert rst at sample 8 of the second window → rate_out=0 and FIFO empty immediately.
